// File: rtl/sw_debounce.sv
// Switch input conditioner: per-bit two-flop synchronizer, stability-counter
// debouncer, and registered rise/fall/changed pulses for the clean levels.
module sw_debounce #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [CW-1:0]    cnt_p2     [WIDTH];
  logic [CW-1:0]    cnt_nxt    [WIDTH];
  logic [WIDTH-1:0] clean_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;

  // Stage p0/p1: metastability guard on the asynchronous switch pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: a mismatch must persist STABLE_CYCLES cycles; any match restarts the count
  always_comb begin
    clean_nxt = sw_clean;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt_p2[i];
      if (sync_p1[i] == sw_clean[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt_p2[i] == LAST) begin
        cnt_nxt[i]   = '0;
        clean_nxt[i] = sync_p1[i];
        rise_nxt[i]  = sync_p1[i];
        fall_nxt[i]  = ~sync_p1[i];
      end else begin
        cnt_nxt[i] = cnt_p2[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt_p2[i] <= '0;
      sw_clean <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
      changed  <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_p2[i] <= cnt_nxt[i];
      sw_clean <= clean_nxt;
      sw_rise  <= rise_nxt;
      sw_fall  <= fall_nxt;
      changed  <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (WIDTH=16, STABLE_CYCLES=4): latency,
// glitch rejection, multi-bit updates and asynchronous reset.
module tb_sw_debounce;

  logic        clk;
  logic        reset;
  logic [15:0] sw;
  logic [15:0] sw_clean;
  logic [15:0] sw_rise;
  logic [15:0] sw_fall;
  logic        changed;

  int n_cmp = 0;
  int n_err = 0;

  sw_debounce #(.WIDTH(16), .STABLE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .changed  (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] c, input logic [15:0] r,
                            input logic [15:0] f, input logic ch);
    chk({tag, "_clean"}, sw_clean, c);
    chk({tag, "_rise"}, sw_rise, r);
    chk({tag, "_fall"}, sw_fall, f);
    chk({tag, "_changed"}, {15'd0, changed}, {15'd0, ch});
  endtask

  // wait one edge, sample on the falling edge
  task automatic cyc(input string tag, input logic [15:0] c, input logic [15:0] r,
                     input logic [15:0] f, input logic ch);
    @(negedge clk);
    check_outs(tag, c, r, f, ch);
  endtask

  // sw was just changed; next posedge is E. Clean level moves on E+5 only.
  task automatic settle(input string tag, input logic [15:0] from_v, input logic [15:0] to_v);
    for (int k = 0; k <= 6; k++) begin
      if (k == 5)
        cyc(tag, to_v, to_v & ~from_v, from_v & ~to_v, (to_v != from_v));
      else
        cyc(tag, (k > 5) ? to_v : from_v, 16'h0, 16'h0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0;
    sw    = 16'h0;

    // asynchronous reset with no clock edge yet
    #2 reset = 1'b1;
    #1 check_outs("rst_async", 16'h0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cyc("idle", 16'h0, 16'h0, 16'h0, 1'b0);

    // single bit rise then fall
    sw = 16'h0001;
    settle("rise0", 16'h0, 16'h0001);
    sw = 16'h0000;
    settle("fall0", 16'h0001, 16'h0);

    // bounce on bit 3 then hold low
    sw = 16'h0008; cyc("bnc3", 16'h0, 16'h0, 16'h0, 1'b0);
    sw = 16'h0000; cyc("bnc3", 16'h0, 16'h0, 16'h0, 1'b0);
    sw = 16'h0008; cyc("bnc3", 16'h0, 16'h0, 16'h0, 1'b0);
    sw = 16'h0000;
    for (int i = 0; i < 8; i++) cyc("bnc3", 16'h0, 16'h0, 16'h0, 1'b0);

    // bit 5: high 2, low 1, then held high
    sw = 16'h0020;
    cyc("bset5", 16'h0, 16'h0, 16'h0, 1'b0);
    cyc("bset5", 16'h0, 16'h0, 16'h0, 1'b0);
    sw = 16'h0000;
    cyc("bset5", 16'h0, 16'h0, 16'h0, 1'b0);
    sw = 16'h0020;
    settle("bset5", 16'h0, 16'h0020);
    sw = 16'h0000;
    settle("bset5f", 16'h0020, 16'h0);

    // two bits together
    sw = 16'h8001;
    settle("simr", 16'h0, 16'h8001);
    sw = 16'h0000;
    settle("simf", 16'h8001, 16'h0);

    // reset mid-count while another bit is already clean-high
    sw = 16'h0001;
    settle("pre", 16'h0, 16'h0001);
    sw = 16'h0081;
    for (int k = 0; k < 4; k++) cyc("mid7", 16'h0001, 16'h0, 16'h0, 1'b0);
    #2 reset = 1'b1;
    #1 check_outs("rst_mid", 16'h0, 16'h0, 16'h0, 1'b0);
    #1 reset = 1'b0;
    settle("post", 16'h0, 16'h0081);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
